exu_bp_update_ctl: RTL and testbench
====================================

// Module: exu_bp_update_ctl
// PURPOSE
//  Receives resolved-branch results from the EXU ALU pipes (mispredict, actual taken, updated 2-bit history, way)
//  and returns them to the IFU branch predictor as BHT/BTB write requests.
//  Decouples ALU resolution timing from predictor write timing with a small in-order FIFO and a valid/ready handshake.
//  Sits between exu (ALU predict_p_ff outputs) and ifu_bp_ctl write ports.
// PARAMETERS
//  DEPTH    4   FIFO entries; power of two, >=2
//  IDX_W    8   BHT/BTB index width taken from resolved PC
//  IDX_LO   3   LSB of PC[31:1] used for the index (index = pc[IDX_LO+IDX_W-1:IDX_LO])
// PORTS
//  clk             in   1      top-level clock
//  rst_l           in   1      reset, asynchronous, active-low
//  res_valid       in   1      resolved branch this cycle (ALU valid_ff & branch)
//  res_pc          in   31     pc_ff[31:1] of resolved branch
//  res_pkt         in   $bits(predict_pkt_t)  predict_p_ff (misp, ataken, hist[1:0], way, ...)
//  flush_bp_clr    in   1      TLU predictor clear: drop all queued updates
//  ifu_bp_halt     in   1      IFU predictor busy (init/scrub): hold issue
//  upd_valid       out  1      write request valid
//  upd_ready       in   1      IFU accepts request
//  upd_index       out  IDX_W  predictor index
//  upd_hist        out  2      new 2-bit counter value
//  upd_way         out  1      BTB way
//  upd_misp        out  1      entry was mispredicted (BTB allocate/invalidate)
//  upd_ataken      out  1      actual direction
//  bpq_full        out  1      FIFO full; decode freeze request
//  bpq_ovf         out  1      sticky: enqueue attempted while full
// BEHAVIOUR
//  Reset: FIFO empty, rd/wr ptrs 0, state RUN, all outputs 0 (bpq_ovf 0).
//  Enqueue on res_valid: {index, hist, way, misp, ataken} written at wr_ptr; wr_ptr++ mod DEPTH.
//  Pointers carry one extra wrap bit: full = ptr LSBs equal & wrap bits differ; empty = ptrs equal.
//  Dequeue when upd_valid & upd_ready; rd_ptr++ mod DEPTH. Outputs are stable while upd_valid & ~upd_ready.
//  Simultaneous enq+deq when full: enqueue allowed (slot frees same cycle), no overflow.
//  Enq while full without deq: entry dropped, bpq_ovf set (cleared only by reset or flush_bp_clr).
//  bpq_full is registered count==DEPTH; deasserts the cycle after a dequeue.
//  Latency: res_valid in cycle N -> upd_valid in cycle N+1 (registered FIFO head) when queue was empty.
//  FSM states: RUN, HALT, CLR.
//   RUN : upd_valid = ~empty. ifu_bp_halt -> HALT (upd_valid drops same cycle unless already handshaking: a
//         request with upd_ready high in the same cycle completes). flush_bp_clr -> CLR.
//   HALT: upd_valid=0, enqueue continues; ~ifu_bp_halt -> RUN.
//   CLR : one cycle; ptrs reset, bpq_ovf cleared, res_valid that cycle discarded; -> RUN (or HALT if ifu_bp_halt).
//  flush_bp_clr has priority over ifu_bp_halt and over any same-cycle enq/deq.
//  Async reset mid-operation: queue contents discarded, state RUN, no partial request emitted.
// CONFIGURATION
//  BP_UPDATE_BYPASS_EN defined: when FIFO empty, state RUN and upd_ready high, res_* drives upd_* combinationally
//   and the entry is not enqueued (0-cycle latency); otherwise normal path.
//  Undefined: always via FIFO, minimum latency 1 cycle, no res->upd combinational path.
// STRUCTURE
//  swerv_types: bp_upd_pkt_t {index, hist[1:0], way, misp, ataken}; bp_upd_state_t enum {RUN,HALT,CLR}.
//  Sub-module: exu_bp_update_fifo (generic DEPTH x $bits(bp_upd_pkt_t) FIFO, rvdffe-based storage, ptrs, full/empty).
//  Top holds FSM, index extraction, overflow sticky, bypass mux.
// TESTING
//  1 res_valid, pc=0x0000_0040, hist=2'b10, upd_ready=1 -> next cycle upd_valid=1, upd_index=pc[10:3], upd_hist=2'b10.
//  2 5 back-to-back res_valid, upd_ready=0, DEPTH=4 -> bpq_full after 4th, 5th dropped, bpq_ovf=1; drain gives 4 in order.
//  3 queue full, res_valid & upd_valid & upd_ready same cycle -> no overflow, count stays 4.
//  4 2 entries queued, ifu_bp_halt=1 for 3 cycles -> upd_valid=0 throughout, 2 entries issued in order after release.
//  5 3 entries queued, bpq_ovf=1, flush_bp_clr pulse with res_valid -> next cycle empty, upd_valid=0, bpq_ovf=0.
//  6 BP_UPDATE_BYPASS_EN, empty, upd_ready=1, res_valid -> upd_valid same cycle, FIFO remains empty.

Source files
------------

// File: rtl/exu_bp_update_ctl_pkg.sv
// Shared types for the EXU -> IFU branch predictor update path.
// Resolved-branch packet, queued update packet and control FSM states.
package exu_bp_update_ctl_pkg;

  localparam int BP_IDX_W = 8;

  typedef struct packed {
    logic       misp;
    logic       ataken;
    logic       boffset;
    logic       pc4;
    logic [1:0] hist;
    logic       way;
  } predict_pkt_t;

  typedef struct packed {
    logic [BP_IDX_W-1:0] index;
    logic [1:0]          hist;
    logic                way;
    logic                misp;
    logic                ataken;
  } bp_upd_pkt_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    CLR  = 2'd2
  } bp_upd_state_t;

  function automatic bp_upd_pkt_t bp_upd_pack(
    input logic [BP_IDX_W-1:0] idx,
    input predict_pkt_t        p
  );
    bp_upd_pkt_t u;
    u.index  = idx;
    u.hist   = p.hist;
    u.way    = p.way;
    u.misp   = p.misp;
    u.ataken = p.ataken;
    return u;
  endfunction

endpackage

// File: rtl/exu_bp_update_fifo.sv
// In-order DEPTH-entry FIFO with wrap-bit pointers.
// Entries held in enabled flops; clr empties it in one cycle.
module exu_bp_update_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Pointer registers; clear wins over any push/pop.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage, one enable per slot.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr_en && !clr) begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_ptr[AW-1:0] == AW'(i))
          mem[i] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/exu_bp_update_ctl.sv
// Queues resolved branches and issues BHT/BTB writes to the IFU.
// Optional BP_UPDATE_BYPASS_EN: zero-latency path when queue idle.
module exu_bp_update_ctl
  import exu_bp_update_ctl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = BP_IDX_W,
  parameter int IDX_LO = 3
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             res_valid,
  input  logic [31:1]      res_pc,
  input  predict_pkt_t     res_pkt,
  input  logic             flush_bp_clr,
  input  logic             ifu_bp_halt,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [IDX_W-1:0] upd_index,
  output logic [1:0]       upd_hist,
  output logic             upd_way,
  output logic             upd_misp,
  output logic             upd_ataken,
  output logic             bpq_full,
  output logic             bpq_ovf
);

  if (IDX_W != BP_IDX_W) begin : g_bad_idx_w
    $error("IDX_W must equal BP_IDX_W");
  end

  bp_upd_state_t state_q;
  bp_upd_state_t state_d;

  bp_upd_pkt_t res_upd;
  bp_upd_pkt_t head_upd;
  bp_upd_pkt_t out_upd;
  bp_upd_pkt_t upd_q;

  logic clr;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_wr;
  logic fifo_rd;
  logic fifo_valid;
  logic bypass;
  logic out_valid;
  logic enq_req;
  logic ovf_set;
  logic ovf_q;
  logic unused_ok;

  assign res_upd = bp_upd_pack(
    res_pc[IDX_LO+IDX_W-1:IDX_LO], res_pkt);

  assign unused_ok = ^{res_pc, res_pkt};

  assign clr = flush_bp_clr || (state_q == CLR);

  // Next state and FIFO-head issue qualification.
  always_comb begin
    state_d    = state_q;
    fifo_valid = 1'b0;
    unique case (state_q)
      RUN: begin
        fifo_valid = !fifo_empty &&
                     (!ifu_bp_halt || upd_ready);
        if (ifu_bp_halt) state_d = HALT;
      end
      HALT: begin
        if (!ifu_bp_halt) state_d = RUN;
      end
      CLR: begin
        state_d = ifu_bp_halt ? HALT : RUN;
      end
      default: state_d = RUN;
    endcase
    if (flush_bp_clr) begin
      state_d    = CLR;
      fifo_valid = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= RUN;
    else        state_q <= state_d;
  end

`ifdef BP_UPDATE_BYPASS_EN
  assign bypass    = res_valid && fifo_empty &&
                     (state_q == RUN) && upd_ready &&
                     !ifu_bp_halt && !flush_bp_clr;
  assign out_valid = fifo_valid || bypass;
  assign out_upd   = bypass ? res_upd : head_upd;
`else
  assign bypass    = 1'b0;
  assign out_valid = fifo_valid;
  assign out_upd   = head_upd;
`endif

  assign fifo_rd = fifo_valid && upd_ready;
  assign enq_req = res_valid && !clr && !bypass;
  assign fifo_wr = enq_req && (!fifo_full || fifo_rd);
  assign ovf_set = enq_req && fifo_full && !fifo_rd;

  exu_bp_update_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(bp_upd_pkt_t))
  ) u_fifo (
    .clk     (clk),
    .rst_l   (rst_l),
    .clr     (clr),
    .wr_en   (fifo_wr),
    .wr_data (res_upd),
    .rd_en   (fifo_rd),
    .rd_data (head_upd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sticky overflow; only reset or a predictor clear drops it.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)       ovf_q <= 1'b0;
    else if (clr)     ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
  end

  assign upd_q      = out_valid ? out_upd : '0;
  assign upd_valid  = out_valid;
  assign upd_index  = upd_q.index;
  assign upd_hist   = upd_q.hist;
  assign upd_way    = upd_q.way;
  assign upd_misp   = upd_q.misp;
  assign upd_ataken = upd_q.ataken;
  assign bpq_full   = fifo_full;
  assign bpq_ovf    = ovf_q;

endmodule

// File: tb/tb_exu_bp_update_ctl.sv
// Directed bench for exu_bp_update_ctl (DEPTH 4, IDX 8 @ pc[10:3]).
// Build with BP_UPDATE_BYPASS_EN to check the bypass variant.
module tb_exu_bp_update_ctl;
  import exu_bp_update_ctl_pkg::*;

  logic         clk;
  logic         rst_l;
  logic         res_valid;
  logic [31:1]  res_pc;
  predict_pkt_t res_pkt;
  logic         flush_bp_clr;
  logic         ifu_bp_halt;
  logic         upd_valid;
  logic         upd_ready;
  logic [7:0]   upd_index;
  logic [1:0]   upd_hist;
  logic         upd_way;
  logic         upd_misp;
  logic         upd_ataken;
  logic         bpq_full;
  logic         bpq_ovf;

  int checks;
  int failures;

  exu_bp_update_ctl #(
    .DEPTH (4), .IDX_W (8), .IDX_LO (3)
  ) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .res_valid    (res_valid),
    .res_pc       (res_pc),
    .res_pkt      (res_pkt),
    .flush_bp_clr (flush_bp_clr),
    .ifu_bp_halt  (ifu_bp_halt),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_index    (upd_index),
    .upd_hist     (upd_hist),
    .upd_way      (upd_way),
    .upd_misp     (upd_misp),
    .upd_ataken   (upd_ataken),
    .bpq_full     (bpq_full),
    .bpq_ovf      (bpq_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] pc, input logic [1:0] h,
                      input logic w, input logic m, input logic a);
    res_valid      = 1'b1;
    res_pc         = pc[31:1];
    res_pkt        = '0;
    res_pkt.hist   = h;
    res_pkt.way    = w;
    res_pkt.misp   = m;
    res_pkt.ataken = a;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    smp();
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++; $display("FAIL rst_valid: got %b exp 0", upd_valid);
    end
    checks++;
    if ({bpq_full, bpq_ovf} !== 2'b00) begin
      failures++; $display("FAIL rst_flags: got %b exp 00", {bpq_full, bpq_ovf});
    end
    checks++;
    if ({upd_index, upd_hist, upd_way, upd_misp, upd_ataken} !== 13'd0) begin
      failures++; $display("FAIL rst_data: got %h exp 0", upd_index);
    end
    tick();
    rst_l = 1'b1;
  endtask

  task automatic test_single();
    upd_ready = 1'b1;
    tick();
    send(32'h40, 2'b10, 1'b0, 1'b0, 1'b1);
    smp();
`ifdef BP_UPDATE_BYPASS_EN
    checks++;
    if ({upd_valid, upd_index, upd_hist, upd_ataken} !== {1'b1, 8'h08, 2'b10, 1'b1}) begin
      failures++; $display("FAIL t1_bypass: got %b %h %b exp 1 08 10", upd_valid, upd_index, upd_hist);
    end
`else
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++; $display("FAIL t1_nocomb: got %b exp 0", upd_valid);
    end
`endif
    tick();
    res_valid = 1'b0;
    smp();
`ifdef BP_UPDATE_BYPASS_EN
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++; $display("FAIL t1_noenq: got %b exp 0", upd_valid);
    end
`else
    checks++;
    if ({upd_valid, upd_index, upd_hist, upd_ataken} !== {1'b1, 8'h08, 2'b10, 1'b1}) begin
      failures++; $display("FAIL t1_issue: got %b %h %b %b exp 1 08 10 1", upd_valid, upd_index, upd_hist, upd_ataken);
    end
`endif
    tick();
    smp();
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++; $display("FAIL t1_drained: got %b exp 0", upd_valid);
    end
  endtask

  task automatic test_overflow();
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      send((i + 1) << 3, 2'(i), i[0], i[1], 1'b0);
      smp();
      if (i == 3) begin
        checks++;
        if (bpq_full !== 1'b0) begin
          failures++; $display("FAIL t2_notfull: got %b exp 0", bpq_full);
        end
      end
      if (i == 4) begin
        checks++;
        if ({bpq_full, bpq_ovf, upd_valid, upd_index} !== {3'b101, 8'h01}) begin
          failures++; $display("FAIL t2_full: got %b%b%b %h exp 101 01", bpq_full, bpq_ovf, upd_valid, upd_index);
        end
      end
    end
    tick();
    res_valid = 1'b0;
    smp();
    checks++;
    if ({bpq_full, bpq_ovf} !== 2'b11) begin
      failures++; $display("FAIL t2_ovf: got %b exp 11", {bpq_full, bpq_ovf});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      upd_ready = 1'b1;
      smp();
      checks++;
      if ({upd_valid, upd_index, upd_hist, upd_way, upd_misp} !==
          {1'b1, 8'(i + 1), 2'(i), i[0], i[1]}) begin
        failures++; $display("FAIL t2_drain%0d: got %b %h %b %b%b exp 1 %h", i, upd_valid, upd_index, upd_hist, upd_way, upd_misp, i + 1);
      end
      checks++;
      if (bpq_full !== (i == 0)) begin
        failures++; $display("FAIL t2_fulldrop%0d: got %b exp %b", i, bpq_full, i == 0);
      end
    end
    tick();
    smp();
    checks++;
    if ({upd_valid, bpq_ovf} !== 2'b01) begin
      failures++; $display("FAIL t2_sticky: got %b exp 01", {upd_valid, bpq_ovf});
    end
    tick();
    upd_ready    = 1'b0;
    flush_bp_clr = 1'b1;
    tick();
    flush_bp_clr = 1'b0;
    smp();
    checks++;
    if (bpq_ovf !== 1'b0) begin
      failures++; $display("FAIL t2_ovfclr: got %b exp 0", bpq_ovf);
    end
    tick();
  endtask

  task automatic test_full_enq_deq();
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      send((5 + i) << 3, 2'b01, 1'b0, 1'b0, 1'b0);
    end
    tick();
    send(9 << 3, 2'b01, 1'b0, 1'b0, 1'b0);
    upd_ready = 1'b1;
    smp();
    checks++;
    if ({bpq_full, upd_valid, upd_index} !== {2'b11, 8'h05}) begin
      failures++; $display("FAIL t3_head: got %b%b %h exp 11 05", bpq_full, upd_valid, upd_index);
    end
    tick();
    res_valid = 1'b0;
    upd_ready = 1'b0;
    smp();
    checks++;
    if ({bpq_full, bpq_ovf, upd_index} !== {2'b10, 8'h06}) begin
      failures++; $display("FAIL t3_count: got %b%b %h exp 10 06", bpq_full, bpq_ovf, upd_index);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      upd_ready = 1'b1;
      smp();
      checks++;
      if ({upd_valid, upd_index} !== {1'b1, 8'(6 + i)}) begin
        failures++; $display("FAIL t3_drain%0d: got %b %h exp 1 %h", i, upd_valid, upd_index, 6 + i);
      end
    end
    tick();
    smp();
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++; $display("FAIL t3_empty: got %b exp 0", upd_valid);
    end
  endtask

  task automatic test_halt();
    upd_ready = 1'b0;
    tick();
    send(32'h11 << 3, 2'b11, 1'b0, 1'b0, 1'b0);
    tick();
    send(32'h12 << 3, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    res_valid   = 1'b0;
    ifu_bp_halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      checks++;
      if (upd_valid !== 1'b0) begin
        failures++; $display("FAIL t4_halt%0d: got %b exp 0", i, upd_valid);
      end
      tick();
      upd_ready = 1'b1;
      if (i == 2) ifu_bp_halt = 1'b0;
    end
    smp();
    checks++;
    if ({upd_valid, upd_index, upd_hist} !== {1'b1, 8'h11, 2'b11}) begin
      failures++; $display("FAIL t4_first: got %b %h exp 1 11", upd_valid, upd_index);
    end
    tick();
    smp();
    checks++;
    if ({upd_valid, upd_index, upd_hist} !== {1'b1, 8'h12, 2'b00}) begin
      failures++; $display("FAIL t4_second: got %b %h exp 1 12", upd_valid, upd_index);
    end
    tick();
    upd_ready = 1'b0;
    send(32'h13 << 3, 2'b01, 1'b0, 1'b0, 1'b0);
    smp();
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++; $display("FAIL t4_empty: got %b exp 0", upd_valid);
    end
    tick();
    res_valid   = 1'b0;
    ifu_bp_halt = 1'b1;
    upd_ready   = 1'b1;
    smp();
    checks++;
    if ({upd_valid, upd_index} !== {1'b1, 8'h13}) begin
      failures++; $display("FAIL t4_handshake: got %b %h exp 1 13", upd_valid, upd_index);
    end
    tick();
    ifu_bp_halt = 1'b0;
    tick();
    smp();
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++; $display("FAIL t4_consumed: got %b exp 0", upd_valid);
    end
  endtask

  task automatic test_flush();
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      send((32'h30 + i) << 3, 2'b10, 1'b0, 1'b0, 1'b0);
    end
    tick();
    res_valid = 1'b0;
    upd_ready = 1'b1;
    smp();
    checks++;
    if ({bpq_ovf, upd_valid, upd_index} !== {2'b11, 8'h30}) begin
      failures++; $display("FAIL t5_pre: got %b%b %h exp 11 30", bpq_ovf, upd_valid, upd_index);
    end
    tick();
    flush_bp_clr = 1'b1;
    send(32'h3F << 3, 2'b10, 1'b0, 1'b0, 1'b0);
    smp();
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++; $display("FAIL t5_flushcyc: got %b exp 0", upd_valid);
    end
    tick();
    flush_bp_clr = 1'b0;
    send(32'h3E << 3, 2'b10, 1'b0, 1'b0, 1'b0);
    smp();
    checks++;
    if ({upd_valid, bpq_ovf, bpq_full} !== 3'b000) begin
      failures++; $display("FAIL t5_clr: got %b exp 000", {upd_valid, bpq_ovf, bpq_full});
    end
    tick();
    res_valid = 1'b0;
    smp();
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++; $display("FAIL t5_discard: got %b %h exp 0", upd_valid, upd_index);
    end
  endtask

  task automatic test_latency();
    upd_ready = 1'b1;
    tick();
    send(32'h7F8, 2'b01, 1'b1, 1'b1, 1'b0);
    smp();
`ifdef BP_UPDATE_BYPASS_EN
    checks++;
    if ({upd_valid, upd_index, upd_hist, upd_way, upd_misp, upd_ataken} !==
        {1'b1, 8'hFF, 2'b01, 3'b110}) begin
      failures++; $display("FAIL t6_bypass: got %b %h %b %b%b%b exp 1 ff 01 110", upd_valid, upd_index, upd_hist, upd_way, upd_misp, upd_ataken);
    end
`else
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++; $display("FAIL t6_nocomb: got %b exp 0", upd_valid);
    end
`endif
    tick();
    res_valid = 1'b0;
    smp();
`ifdef BP_UPDATE_BYPASS_EN
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++; $display("FAIL t6_noenq: got %b exp 0", upd_valid);
    end
`else
    checks++;
    if ({upd_valid, upd_index, upd_hist, upd_way, upd_misp, upd_ataken} !==
        {1'b1, 8'hFF, 2'b01, 3'b110}) begin
      failures++; $display("FAIL t6_issue: got %b %h %b %b%b%b exp 1 ff 01 110", upd_valid, upd_index, upd_hist, upd_way, upd_misp, upd_ataken);
    end
`endif
    tick();
    smp();
    checks++;
    if ({upd_valid, bpq_full} !== 2'b00) begin
      failures++; $display("FAIL t6_after: got %b exp 00", {upd_valid, bpq_full});
    end
  endtask

  task automatic test_async_reset();
    upd_ready = 1'b0;
    tick();
    send(32'h41 << 3, 2'b11, 1'b1, 1'b1, 1'b1);
    tick();
    send(32'h42 << 3, 2'b11, 1'b1, 1'b1, 1'b1);
    tick();
    res_valid = 1'b0;
    smp();
    checks++;
    if ({upd_valid, upd_index} !== {1'b1, 8'h41}) begin
      failures++; $display("FAIL t7_pre: got %b %h exp 1 41", upd_valid, upd_index);
    end
    #1;
    rst_l = 1'b0;
    #1;
    checks++;
    if ({upd_valid, upd_index, upd_hist, upd_way, upd_misp, upd_ataken} !== 13'd0) begin
      failures++; $display("FAIL t7_async: got %b %h exp 0 00", upd_valid, upd_index);
    end
    tick();
    rst_l     = 1'b1;
    upd_ready = 1'b1;
    smp();
    checks++;
    if ({upd_valid, bpq_full, bpq_ovf} !== 3'b000) begin
      failures++; $display("FAIL t7_post: got %b exp 000", {upd_valid, bpq_full, bpq_ovf});
    end
    tick();
    smp();
    checks++;
    if (upd_valid !== 1'b0) begin
      failures++; $display("FAIL t7_gone: got %b exp 0", upd_valid);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_l        = 1'b0;
    res_valid    = 1'b0;
    res_pc       = '0;
    res_pkt      = '0;
    flush_bp_clr = 1'b0;
    ifu_bp_halt  = 1'b0;
    upd_ready    = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_enq_deq();
    test_halt();
    test_flush();
    test_latency();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
